// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle unsigned add/sub/mul/div behind valid/ready
// handshakes. Add and subtract finish right after the decode cycle. Multiply
// (shift-add) and divide (restoring) iterate one bit per cycle, MSB first.
module seq_calculator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add,
    input  logic             subtract,
    input  logic             divide,
    input  logic             multiply,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             invalid_input,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(WIDTH);

    // DECODE is the cycle between acceptance and the first result/iteration,
    // working only from the latched request.
    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               op_add;
    logic               op_sub;
    logic               op_mul;
    logic               op_div;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quot;

    logic               op_bad;
    logic               div_zero;
    logic [WIDTH:0]     sum_ext;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quot_next;

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);

    // Request decode plus the single iteration step of the multiplier and divider
    always_comb begin
        op_bad    = ($countones({op_add, op_sub, op_mul, op_div}) != 1);
        div_zero  = op_div && (b_reg == '0);
        sum_ext   = {1'b0, a_reg} + {1'b0, b_reg};
        mul_next  = {acc[2*WIDTH-2:0], 1'b0}
                  + (b_reg[count] ? {{WIDTH{1'b0}}, a_reg} : {(2*WIDTH){1'b0}});
        rem_shift = {rem[WIDTH-1:0], a_reg[count]};
        rem_ge    = (rem_shift >= {1'b0, b_reg});
        rem_next  = rem_ge ? (rem_shift - {1'b0, b_reg}) : rem_shift;
        quot_next = {quot[WIDTH-2:0], rem_ge};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (op_bad || div_zero) begin
                    next_state = DONE;
                end else if (op_mul) begin
                    next_state = MUL;
                end else if (op_div) begin
                    next_state = DIV;
                end else begin
                    next_state = DONE;
                end
            end
            MUL, DIV: begin
                if (count == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration registers and the registered output fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            op_add        <= 1'b0;
            op_sub        <= 1'b0;
            op_mul        <= 1'b0;
            op_div        <= 1'b0;
            count         <= '0;
            acc           <= '0;
            rem           <= '0;
            quot          <= '0;
            result        <= '0;
            remainder     <= '0;
            overflow      <= 1'b0;
            invalid_input <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_add <= add;
                        op_sub <= subtract;
                        op_mul <= multiply;
                        op_div <= divide;
                    end
                end
                DECODE: begin
                    if (op_bad || div_zero) begin
                        result        <= '0;
                        remainder     <= '0;
                        overflow      <= 1'b0;
                        invalid_input <= 1'b1;
                    end else if (op_add) begin
                        result        <= sum_ext[WIDTH-1:0];
                        remainder     <= '0;
                        overflow      <= sum_ext[WIDTH];
                        invalid_input <= 1'b0;
                    end else if (op_sub) begin
                        result        <= a_reg - b_reg;
                        remainder     <= '0;
                        overflow      <= (a_reg < b_reg);
                        invalid_input <= 1'b0;
                    end else if (op_mul) begin
                        acc   <= '0;
                        count <= CW'(WIDTH - 1);
                    end else begin
                        rem   <= '0;
                        quot  <= '0;
                        count <= CW'(WIDTH - 1);
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        result        <= mul_next[WIDTH-1:0];
                        remainder     <= '0;
                        overflow      <= |mul_next[2*WIDTH-1:WIDTH];
                        invalid_input <= 1'b0;
                    end
                end
                DIV: begin
                    rem   <= rem_next;
                    quot  <= quot_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        result        <= quot_next;
                        remainder     <= rem_next[WIDTH-1:0];
                        overflow      <= 1'b0;
                        invalid_input <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed and randomized checks of seq_calculator against an arithmetic
// reference model (latency, result fields, backpressure, mid-operation reset).
module tb_seq_calculator;

    localparam int W = 16;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0001;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         add;
    logic         subtract;
    logic         divide;
    logic         multiply;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         overflow;
    logic         invalid_input;
    logic         out_valid;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    seq_calculator #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .add          (add),
        .subtract     (subtract),
        .divide       (divide),
        .multiply     (multiply),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .result       (result),
        .remainder    (remainder),
        .overflow     (overflow),
        .invalid_input(invalid_input),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain unsigned arithmetic on the operation selected
    task automatic modelResult(input logic [3:0] ops, input longint av, input longint bv,
                               output longint res, output longint rem,
                               output logic ov, output logic inv, output int lat);
        longint m;
        longint t;
        m   = longint'(1) << W;
        res = 0;
        rem = 0;
        ov  = 1'b0;
        inv = 1'b0;
        lat = 1;
        if ($countones(ops) != 1 || (ops == OP_DIV && bv == 0)) begin
            inv = 1'b1;
        end else if (ops == OP_ADD) begin
            t   = av + bv;
            res = t % m;
            ov  = (t >= m);
        end else if (ops == OP_SUB) begin
            res = (av - bv + m) % m;
            ov  = (av < bv);
        end else if (ops == OP_MUL) begin
            t   = av * bv;
            res = t % m;
            ov  = (t >= m);
            lat = W + 1;
        end else begin
            res = av / bv;
            rem = av % bv;
            lat = W + 1;
        end
    endtask

    // Present one request and let it be accepted, then scramble the inputs
    task automatic applyStimulus(input logic [3:0] ops, input logic [W-1:0] av,
                                 input logic [W-1:0] bv);
        @(negedge clk);
        {add, subtract, multiply, divide} = ops;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        {add, subtract, multiply, divide} = 4'($urandom);
        @(negedge clk);
        checkOutput("out_valid_early", 32'(out_valid), 32'd0);
    endtask

    // Wait (bounded) for out_valid, then compare latency and fields to the model
    task automatic waitResult(input string tag, input logic [3:0] ops,
                              input logic [W-1:0] av, input logic [W-1:0] bv);
        longint exp_res;
        longint exp_rem;
        logic   exp_ov;
        logic   exp_inv;
        int     exp_lat;
        int     lat;
        modelResult(ops, longint'(av), longint'(bv), exp_res, exp_rem, exp_ov, exp_inv, exp_lat);
        lat = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = cyc;
                break;
            end
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_result"}, 32'(result), 32'(exp_res));
        checkOutput({tag, "_remainder"}, 32'(remainder), 32'(exp_rem));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(exp_ov));
        checkOutput({tag, "_invalid"}, 32'(invalid_input), 32'(exp_inv));
    endtask

    // Take the result with a single out_ready pulse and confirm the return to idle
    task automatic finishResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("out_valid_after_take", 32'(out_valid), 32'd0);
        checkOutput("in_ready_after_take", 32'(in_ready), 32'd1);
    endtask

    task automatic runTransaction(input string tag, input logic [3:0] ops,
                                  input logic [W-1:0] av, input logic [W-1:0] bv);
        applyStimulus(ops, av, bv);
        waitResult(tag, ops, av, bv);
        finishResult();
    endtask

    // Directed test plan followed by randomized transactions
    initial begin
        logic [3:0]   rops;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen;

        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        {add, subtract, multiply, divide} = 4'b0000;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        #3;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_invalid", 32'(invalid_input), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_release", 32'(in_ready), 32'd1);

        $display("[TB] directed operations");
        runTransaction("add_wrap", OP_ADD, 16'hFFFF, 16'h0001);
        runTransaction("sub_borrow", OP_SUB, 16'd3, 16'd5);
        runTransaction("mul_300", OP_MUL, 16'd300, 16'd300);
        runTransaction("mul_ff", OP_MUL, 16'h00FF, 16'h00FF);
        runTransaction("div_1000_7", OP_DIV, 16'd1000, 16'd7);
        runTransaction("div_zero", OP_DIV, 16'd1234, 16'd0);
        runTransaction("add_and_mul", OP_ADD | OP_MUL, 16'd10, 16'd20);
        runTransaction("no_op", 4'b0000, 16'd10, 16'd20);

        $display("[TB] backpressure");
        applyStimulus(OP_SUB, 16'd5, 16'd3);
        waitResult("sub_plain", OP_SUB, 16'd5, 16'd3);
        for (int i = 0; i < 5; i++) begin
            {add, subtract, multiply, divide} = OP_ADD;
            a        = 16'h0100;
            b        = 16'h0200;
            in_valid = 1'b1;
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_result", 32'(result), 32'd2);
            checkOutput("bp_overflow", 32'(overflow), 32'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
        end
        finishResult();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("bp_ignored_request", 32'(seen), 32'd0);

        runTransaction("div_equal", OP_DIV, 16'h1234, 16'h1234);

        $display("[TB] reset during multiply");
        applyStimulus(OP_MUL, 16'd1234, 16'd567);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_result", 32'(result), 32'd0);
        checkOutput("midreset_remainder", 32'(remainder), 32'd0);
        checkOutput("midreset_overflow", 32'(overflow), 32'd0);
        checkOutput("midreset_invalid", 32'(invalid_input), 32'd0);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("midreset_no_result", 32'(seen), 32'd0);
        runTransaction("add_after_reset", OP_ADD, 16'd40000, 16'd30000);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                rops = 4'($urandom);
            end else begin
                rops = 4'b0001 << $urandom_range(0, 3);
            end
            ra = W'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                rb = W'($urandom_range(0, 3));
            end else begin
                rb = W'($urandom);
            end
            runTransaction("random", rops, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
